// File: rtl/framebuffer_writer.sv
// framebuffer_writer
// Terminal stage of the raster pixel stream. Clips incoming pixels to the
// framebuffer, packs colour to RGB565, forms the linear word address, buffers
// results in a FIFO and drains them to the memory port through a
// first-word-fall-through output register. An almost-full stall is raised
// early enough to absorb the pixels already in flight in the raster pipeline.

module framebuffer_writer #(
  parameter int FB_WIDTH     = 640,
  parameter int FB_HEIGHT    = 480,
  parameter int ADDR_W       = 20,
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_write_pixel,
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  input  logic [7:0]         i_r,
  input  logic [7:0]         i_g,
  input  logic [7:0]         i_b,
  input  logic [ADDR_W-1:0]  i_fb_base,
  input  logic               i_clear_stats,
  output logic               o_stall,
  output logic               o_mem_valid,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [15:0]        o_mem_data,
  input  logic               i_mem_ready,
  output logic               o_overflow,
  output logic [31:0]        o_pixel_count,
  output logic [31:0]        o_clip_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 16;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(FIFO_DEPTH - STALL_MARGIN);

  // Clip and address arithmetic are done on sign-extended coordinates so
  // negative positions compare correctly against the framebuffer bounds.
  logic signed [31:0] x_s;
  logic signed [31:0] y_s;
  logic               in_range;
  logic [ADDR_W-1:0]  addr_calc;
  logic [15:0]        data_calc;

  // The low colour bits are deliberately thrown away by RGB565 packing.
  logic unused_colour_lsbs;

  // Stage-1 pipeline register (clipped, packed, addressed pixel).
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [15:0]       s1_data;

  // FIFO storage and bookkeeping.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_next;
  logic [ENTRY_W-1:0] fifo_head;

  // Handshake and flow-control decisions for the current cycle.
  logic out_free;
  logic fifo_empty;
  logic fifo_full;
  logic fifo_pop;
  logic fifo_push;
  logic bypass;
  logic drop;
  logic transfer;

  assign x_s = i_x;
  assign y_s = i_y;

  assign in_range = (x_s >= 0) && (x_s < FB_WIDTH) &&
                    (y_s >= 0) && (y_s < FB_HEIGHT);

  assign addr_calc = i_fb_base + ADDR_W'(y_s * FB_WIDTH + x_s);
  assign data_calc = {i_r[7:3], i_g[7:2], i_b[7:3]};

  assign unused_colour_lsbs = ^{i_r[2:0], i_g[1:0], i_b[2:0]};

  assign fifo_head  = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C);

  // The output register can take a new entry when it is empty or when its
  // current entry is leaving this cycle.
  assign out_free = !o_mem_valid || i_mem_ready;
  assign transfer = o_mem_valid && i_mem_ready;

  // The FIFO head always has priority for the output register so ordering
  // is kept; a stage-1 pixel only skips the FIFO when the FIFO is empty.
  assign fifo_pop  = out_free && !fifo_empty;
  assign bypass    = out_free && fifo_empty && s1_valid;
  assign fifo_push = s1_valid && !bypass && (!fifo_full || fifo_pop);
  assign drop      = s1_valid && !bypass && fifo_full && !fifo_pop;

  // Next FIFO occupancy, used both for the count register and the stall flag.
  always_comb begin
    count_next = fifo_count;
    if (fifo_push && !fifo_pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (fifo_pop && !fifo_push) begin
      count_next = fifo_count - CNT_W'(1);
    end
  end

  // Stage 1: register clip result, packed colour and address of each pixel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= i_write_pixel && in_range;
      if (i_write_pixel && in_range) begin
        s1_addr <= addr_calc;
        s1_data <= data_calc;
      end
    end
  end

  // FIFO storage: written on push, contents need no reset.
  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {s1_addr, s1_data};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_next;
    end
  end

  // Output register: reloads from the FIFO head (or directly from stage 1
  // when the FIFO is empty) on the same edge that a transfer completes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
    end else if (out_free) begin
      if (fifo_pop) begin
        o_mem_valid <= 1'b1;
        o_mem_addr  <= fifo_head[ENTRY_W-1:16];
        o_mem_data  <= fifo_head[15:0];
      end else if (bypass) begin
        o_mem_valid <= 1'b1;
        o_mem_addr  <= s1_addr;
        o_mem_data  <= s1_data;
      end else begin
        o_mem_valid <= 1'b0;
      end
    end
  end

  // Stall tracks FIFO occupancy after this edge, excluding the output register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall <= 1'b0;
    end else begin
      o_stall <= (count_next >= STALL_AT);
    end
  end

  // Statistics: clear wins over any increment in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pixel_count <= '0;
      o_clip_count  <= '0;
      o_overflow    <= 1'b0;
    end else if (i_clear_stats) begin
      o_pixel_count <= '0;
      o_clip_count  <= '0;
      o_overflow    <= 1'b0;
    end else begin
      if (transfer) begin
        o_pixel_count <= o_pixel_count + 32'd1;
      end
      if (i_write_pixel && !in_range) begin
        o_clip_count <= o_clip_count + 32'd1;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer
// Drives framebuffer_writer with directed and randomized pixel streams and
// compares its outputs against a queue-based transaction model: the output
// register plus FIFO are treated as one ordered store of FIFO_DEPTH+1 pixels.

module tb_framebuffer_writer;

  localparam int FB_WIDTH     = 640;
  localparam int FB_HEIGHT    = 480;
  localparam int ADDR_W       = 20;
  localparam int FIFO_DEPTH   = 16;
  localparam int STALL_MARGIN = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } ent_t;

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_write_pixel = 1'b0;
  logic signed [15:0] i_x = '0;
  logic signed [15:0] i_y = '0;
  logic [7:0]         i_r = '0;
  logic [7:0]         i_g = '0;
  logic [7:0]         i_b = '0;
  logic [ADDR_W-1:0]  i_fb_base = '0;
  logic               i_clear_stats = 1'b0;
  logic               i_mem_ready = 1'b0;
  logic               o_stall;
  logic               o_mem_valid;
  logic [ADDR_W-1:0]  o_mem_addr;
  logic [15:0]        o_mem_data;
  logic               o_overflow;
  logic [31:0]        o_pixel_count;
  logic [31:0]        o_clip_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  ent_t        mq[$];
  bit          m_s1_v;
  ent_t        m_s1_e;
  int unsigned m_pix;
  int unsigned m_clip;
  bit          m_ovf;

  always #5 i_clk = ~i_clk;

  framebuffer_writer #(
    .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .STALL_MARGIN(STALL_MARGIN)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_write_pixel(i_write_pixel),
    .i_x(i_x), .i_y(i_y), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_fb_base(i_fb_base), .i_clear_stats(i_clear_stats), .o_stall(o_stall),
    .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_ready(i_mem_ready), .o_overflow(o_overflow),
    .o_pixel_count(o_pixel_count), .o_clip_count(o_clip_count)
  );

  task automatic model_reset();
    mq.delete();
    m_s1_v = 0;
    m_s1_e = '0;
    m_pix  = 0;
    m_clip = 0;
    m_ovf  = 0;
  endtask

  // One clock edge of the transaction model, using the inputs held this cycle
  task automatic model_edge();
    int     xi;
    int     yi;
    longint a;
    int     d;
    if (!i_reset_n) begin
      model_reset();
      return;
    end
    if (mq.size() > 0 && i_mem_ready) begin
      mq.delete(0);
      m_pix++;
    end
    if (m_s1_v) begin
      if (mq.size() < FIFO_DEPTH + 1) mq.push_back(m_s1_e);
      else m_ovf = 1;
    end
    m_s1_v = 0;
    if (i_write_pixel) begin
      xi = int'(i_x);
      yi = int'(i_y);
      if (xi >= 0 && xi < FB_WIDTH && yi >= 0 && yi < FB_HEIGHT) begin
        a = (longint'(i_fb_base) + longint'(yi) * FB_WIDTH + xi) % (longint'(1) << ADDR_W);
        d = (int'(i_r) / 8) * 2048 + (int'(i_g) / 4) * 32 + (int'(i_b) / 8);
        m_s1_v = 1;
        m_s1_e.addr = a[ADDR_W-1:0];
        m_s1_e.data = d[15:0];
      end else begin
        m_clip++;
      end
    end
    if (i_clear_stats) begin
      m_pix  = 0;
      m_clip = 0;
      m_ovf  = 0;
    end
  endtask

  function automatic bit model_stall();
    int occ;
    occ = (mq.size() > 0) ? mq.size() - 1 : 0;
    return occ >= FIFO_DEPTH - STALL_MARGIN;
  endfunction

  // Advance one clock; inputs are applied at the falling edge before this
  task automatic tick();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic drive_pixel(input int x, input int y, input logic [ADDR_W-1:0] base,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    i_write_pixel = 1'b1;
    i_x = 16'(x);
    i_y = 16'(y);
    i_fb_base = base;
    i_r = r;
    i_g = g;
    i_b = b;
  endtask

  task automatic drive_rand_inrange();
    drive_pixel(int'($urandom_range(0, FB_WIDTH - 1)), int'($urandom_range(0, FB_HEIGHT - 1)),
                ADDR_W'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic idle();
    i_write_pixel = 1'b0;
  endtask

  task automatic clear_stats();
    idle();
    i_clear_stats = 1'b1;
    tick();
    i_clear_stats = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    i_mem_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    model_reset();
    i_reset_n = 1'b0;
    #12;
    checks++;
    if (o_mem_valid !== 1'b0 || o_stall !== 1'b0 || o_overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: valid=%b stall=%b ovf=%b required 0 0 0", o_mem_valid, o_stall, o_overflow);
    end
    checks++;
    if (o_pixel_count !== 32'd0 || o_clip_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters: pix=%0d clip=%0d required 0 0", o_pixel_count, o_clip_count);
    end
    i_reset_n = 1'b1;
    @(negedge i_clk);
    tick();
    checks++;
    if (o_mem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle_valid: got %b required 0", o_mem_valid);
    end
  endtask

  task automatic test_single_pixel();
    clear_stats();
    i_mem_ready = 1'b1;
    drive_pixel(10, 2, 20'h100, 8'hFF, 8'h80, 8'h08);
    tick();
    idle();
    checks++;
    if (o_mem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_cycle1_valid: got %b required 0", o_mem_valid);
    end
    tick();
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 20'h0060A || o_mem_data !== 16'hFC01) begin
      failures++;
      $display("[TB] FAIL single_cycle2: valid=%b addr=%h data=%h required 1 0060a fc01", o_mem_valid, o_mem_addr, o_mem_data);
    end
    tick();
    checks++;
    if (o_pixel_count !== 32'd1 || o_mem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_count: pix=%0d valid=%b required 1 0", o_pixel_count, o_mem_valid);
    end
  endtask

  task automatic test_clipping();
    int cx[4] = '{-1, 640, 3, 0};
    int cy[4] = '{0, 5, 480, -7};
    clear_stats();
    i_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_pixel(cx[i], cy[i], 20'h100, 8'hAA, 8'hBB, 8'hCC);
      tick();
      checks++;
      if (o_mem_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL clip_no_valid[%0d]: got %b required 0", i, o_mem_valid);
      end
    end
    idle();
    tick();
    checks++;
    if (o_clip_count !== 32'd4 || o_mem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clip_count: clip=%0d valid=%b required 4 0", o_clip_count, o_mem_valid);
    end
    drive_pixel(639, 479, 20'h100, 8'h12, 8'h34, 8'h56);
    tick();
    idle();
    tick();
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 20'h4B0FF || o_mem_data !== 16'h11AA) begin
      failures++;
      $display("[TB] FAIL clip_corner: valid=%b addr=%h data=%h required 1 4b0ff 11aa", o_mem_valid, o_mem_addr, o_mem_data);
    end
    drain(2);
  endtask

  task automatic test_backpressure();
    clear_stats();
    i_mem_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive_rand_inrange();
      tick();
      checks++;
      if (o_mem_valid !== (mq.size() > 0) ||
          (mq.size() > 0 && {o_mem_addr, o_mem_data} !== {mq[0].addr, mq[0].data})) begin
        failures++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%b addr=%h data=%h", i, o_mem_valid, o_mem_addr, o_mem_data);
      end
    end
    idle();
    checks++;
    if (o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_stall_occ11: got %b required 0", o_stall);
    end
    tick();
    checks++;
    if (o_stall !== 1'b1 || o_overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_stall_occ12: stall=%b ovf=%b required 1 0", o_stall, o_overflow);
    end
    i_mem_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (o_mem_valid !== 1'b1 || mq.size() == 0 ||
          {o_mem_addr, o_mem_data} !== {mq[0].addr, mq[0].data}) begin
        failures++;
        $display("[TB] FAIL bp_drain[%0d]: valid=%b addr=%h data=%h", i, o_mem_valid, o_mem_addr, o_mem_data);
      end
      tick();
    end
    checks++;
    if (o_mem_valid !== 1'b0 || o_pixel_count !== 32'd13) begin
      failures++;
      $display("[TB] FAIL bp_done: valid=%b pix=%0d required 0 13", o_mem_valid, o_pixel_count);
    end
  endtask

  task automatic test_overflow();
    clear_stats();
    i_mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_rand_inrange();
      tick();
    end
    idle();
    tick();
    checks++;
    if (o_overflow !== 1'b1 || o_stall !== 1'b1 || o_mem_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_set: ovf=%b stall=%b valid=%b required 1 1 1", o_overflow, o_stall, o_mem_valid);
    end
    i_mem_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (o_mem_valid !== 1'b1 || mq.size() == 0 ||
          {o_mem_addr, o_mem_data} !== {mq[0].addr, mq[0].data}) begin
        failures++;
        $display("[TB] FAIL ovf_drain[%0d]: valid=%b addr=%h data=%h", i, o_mem_valid, o_mem_addr, o_mem_data);
      end
      tick();
    end
    checks++;
    if (o_mem_valid !== 1'b0 || o_pixel_count !== 32'd17 || o_overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_kept: valid=%b pix=%0d ovf=%b required 0 17 1", o_mem_valid, o_pixel_count, o_overflow);
    end
    clear_stats();
    checks++;
    if (o_overflow !== 1'b0 || o_pixel_count !== 32'd0 || o_clip_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL ovf_clear: ovf=%b pix=%0d clip=%0d required 0 0 0", o_overflow, o_pixel_count, o_clip_count);
    end
  endtask

  task automatic test_reset_midstream();
    i_mem_ready = 1'b0;
    drive_pixel(-5, -5, 20'h0, 8'h00, 8'h00, 8'h00);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_rand_inrange();
      tick();
    end
    idle();
    tick();
    checks++;
    if (o_clip_count !== 32'd1 || o_mem_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_pre: clip=%0d valid=%b required 1 1", o_clip_count, o_mem_valid);
    end
    #2;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_mem_valid !== 1'b0 || o_pixel_count !== 32'd0 || o_clip_count !== 32'd0 ||
        o_stall !== 1'b0 || o_overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_async: valid=%b pix=%0d clip=%0d stall=%b ovf=%b required all 0",
               o_mem_valid, o_pixel_count, o_clip_count, o_stall, o_overflow);
    end
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b1;
    drive_pixel(1, 1, 20'h0, 8'hFF, 8'hFF, 8'hFF);
    tick();
    idle();
    checks++;
    if (o_mem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_cycle1: got %b required 0", o_mem_valid);
    end
    tick();
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 20'h00281 || o_mem_data !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL rstmid_cycle2: valid=%b addr=%h data=%h required 1 00281 ffff", o_mem_valid, o_mem_addr, o_mem_data);
    end
    drain(2);
  endtask

  task automatic test_full_boundary();
    clear_stats();
    i_mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive_rand_inrange();
      tick();
    end
    checks++;
    if (o_overflow !== 1'b0 || o_stall !== 1'b1 || mq.size() != FIFO_DEPTH + 1) begin
      failures++;
      $display("[TB] FAIL full_prep: ovf=%b stall=%b required 0 1", o_overflow, o_stall);
    end
    i_mem_ready = 1'b1;
    drive_rand_inrange();
    tick();
    idle();
    checks++;
    if (o_overflow !== 1'b0 || o_pixel_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL full_concurrent: ovf=%b pix=%0d required 0 1", o_overflow, o_pixel_count);
    end
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (o_mem_valid !== 1'b1 || mq.size() == 0 ||
          {o_mem_addr, o_mem_data} !== {mq[0].addr, mq[0].data}) begin
        failures++;
        $display("[TB] FAIL full_order[%0d]: valid=%b addr=%h data=%h", i, o_mem_valid, o_mem_addr, o_mem_data);
      end
      tick();
    end
    checks++;
    if (o_mem_valid !== 1'b0 || o_pixel_count !== 32'd19 || o_overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_done: valid=%b pix=%0d ovf=%b required 0 19 0", o_mem_valid, o_pixel_count, o_overflow);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) < 70) begin
        drive_pixel(int'($urandom_range(0, 700)) - 30, int'($urandom_range(0, 540)) - 30,
                    ADDR_W'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        idle();
      end
      i_mem_ready   = ($urandom_range(0, 99) < 60);
      i_clear_stats = ($urandom_range(0, 99) < 2);
      tick();
      checks++;
      if (o_mem_valid !== (mq.size() > 0) ||
          (mq.size() > 0 && {o_mem_addr, o_mem_data} !== {mq[0].addr, mq[0].data})) begin
        failures++;
        $display("[TB] FAIL rand_out[%0d]: valid=%b addr=%h data=%h model_size=%0d", c, o_mem_valid, o_mem_addr, o_mem_data, mq.size());
      end
      checks++;
      if (o_stall !== model_stall() || o_overflow !== m_ovf) begin
        failures++;
        $display("[TB] FAIL rand_flags[%0d]: stall=%b ovf=%b required %b %b", c, o_stall, o_overflow, model_stall(), m_ovf);
      end
      checks++;
      if (o_pixel_count !== m_pix || o_clip_count !== m_clip) begin
        failures++;
        $display("[TB] FAIL rand_counts[%0d]: pix=%0d clip=%0d required %0d %0d", c, o_pixel_count, o_clip_count, m_pix, m_clip);
      end
    end
    i_clear_stats = 1'b0;
    drain(25);
    checks++;
    if (o_mem_valid !== 1'b0 || o_pixel_count !== m_pix) begin
      failures++;
      $display("[TB] FAIL rand_drain: valid=%b pix=%0d required 0 %0d", o_mem_valid, o_pixel_count, m_pix);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_clipping();
    test_backpressure();
    test_overflow();
    test_reset_midstream();
    test_full_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
